sram_1rw1r_sync: RTL and testbench

Parametrised successor to the team's 1RW1R SRAM behavioural model. One shared clock, with both ports registered on the rising edge. Adds per-port read-valid strobes, configurable byte-mask granularity, same-cycle write-to-read forwarding and a collision flag. A post-reset clear sequencer zeroes the array and raises ready. It serves as the simulation and FPGA stand-in for OpenRAM macros in the SoC memory subsystem.

---
 rtl/sram_1rw1r_sync.sv | 140 ++++++++++++++
 tb/tb_sram_1rw1r_sync.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1rw1r_sync.sv
// 1RW1R synchronous SRAM model: one write/read port, one read port, shared rising-edge clock.
// Adds read-valid strobes, lane masking, same-address write-to-read forwarding and a post-reset clear sequencer.
module sram_1rw1r_sync #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 9,
    parameter int unsigned MASK_GRAN      = 8,
    parameter int unsigned NUM_WMASKS     = DATA_WIDTH / MASK_GRAN,
    parameter bit          FORWARD        = 1'b1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic                  dout0_valid,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  dout1_valid,
    output logic                  collision,
    output logic                  ready
);

    localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_CLEAR      = 2'd0,
        S_READY_PEND = 2'd1,
        S_READY      = 2'd2
    } state_t;

    localparam state_t RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_READY_PEND;

    logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;
    logic                  w_clear_we;

    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_dout0;
    logic [DATA_WIDTH-1:0] r_dout1;
    logic                  r_dout0_valid;
    logic                  r_dout1_valid;
    logic                  r_collision;

    logic                  w_wr0;
    logic                  w_rd0;
    logic                  w_rd1;
    logic                  w_coll;
    logic [DATA_WIDTH-1:0] w_old1;
    logic [DATA_WIDTH-1:0] w_merge1;
    logic [DATA_WIDTH-1:0] w_rdata1;

    // Requests only count once the sequencer has handed over the array.
    assign w_wr0  = r_ready & ~csb0 & ~web0;
    assign w_rd0  = r_ready & ~csb0 &  web0;
    assign w_rd1  = r_ready & ~csb1;
    assign w_coll = w_wr0 & w_rd1 & (addr0 == addr1);
    assign w_old1 = r_mem[addr1];

    for (genvar i = 0; i < NUM_WMASKS; i++) begin : gen_lane
        assign w_merge1[i*MASK_GRAN +: MASK_GRAN] = wmask0[i] ? din0[i*MASK_GRAN +: MASK_GRAN]
                                                              : w_old1[i*MASK_GRAN +: MASK_GRAN];
    end

    assign w_rdata1 = (FORWARD && w_coll) ? w_merge1 : w_old1;

    // Clear sequencer next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_clear_we  = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_clear_we = 1'b1;
                w_cnt_nxt  = r_cnt + ADDR_WIDTH'(1);
                if (r_cnt == {ADDR_WIDTH{1'b1}}) begin
                    w_state_nxt = S_READY;
                end
            end
            S_READY_PEND: w_state_nxt = S_READY;
            S_READY:      w_state_nxt = S_READY;
            default:      w_state_nxt = RST_STATE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RST_STATE;
            r_cnt         <= '0;
            r_ready       <= 1'b0;
            r_dout0       <= '0;
            r_dout1       <= '0;
            r_dout0_valid <= 1'b0;
            r_dout1_valid <= 1'b0;
            r_collision   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_ready       <= (w_state_nxt == S_READY);
            r_dout0_valid <= w_rd0;
            r_dout1_valid <= w_rd1;
            r_collision   <= w_coll;
            if (w_rd0) begin
                r_dout0 <= r_mem[addr0];
            end
            if (w_rd1) begin
                r_dout1 <= w_rdata1;
            end
        end
    end

    // Array storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (w_clear_we) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr0) begin
            for (int i = 0; i < NUM_WMASKS; i++) begin
                if (wmask0[i]) begin
                    r_mem[addr0][i*MASK_GRAN +: MASK_GRAN] <= din0[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    assign dout0       = r_dout0;
    assign dout1       = r_dout1;
    assign dout0_valid = r_dout0_valid;
    assign dout1_valid = r_dout1_valid;
    assign collision   = r_collision;
    assign ready       = r_ready;

endmodule

// File: tb/tb_sram_1rw1r_sync.sv
// Bench for sram_1rw1r_sync: two instances (32b/8b lanes forwarding, 64b/16b lanes non-forwarding)
// checked every cycle against an array-based reference model.
module tb_sram_1rw1r_sync;

    localparam int unsigned A_DEPTH = 16;
    localparam int unsigned B_DEPTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_csb0 = 1'b1, a_web0 = 1'b1, a_csb1 = 1'b1;
    logic [3:0]  a_wmask0 = '0, a_addr0 = '0, a_addr1 = '0;
    logic [31:0] a_din0 = '0;
    logic [31:0] a_dout0, a_dout1;
    logic        a_v0, a_v1, a_col, a_rdy;

    logic        b_csb0 = 1'b1, b_web0 = 1'b1, b_csb1 = 1'b1;
    logic [3:0]  b_wmask0 = '0;
    logic [2:0]  b_addr0 = '0, b_addr1 = '0;
    logic [63:0] b_din0 = '0;
    logic [63:0] b_dout0, b_dout1;
    logic        b_v0, b_v1, b_col, b_rdy;

    sram_1rw1r_sync #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .MASK_GRAN(8),
                      .FORWARD(1'b1), .CLEAR_ON_RESET(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .csb0(a_csb0), .web0(a_web0), .wmask0(a_wmask0), .addr0(a_addr0), .din0(a_din0),
        .dout0(a_dout0), .dout0_valid(a_v0),
        .csb1(a_csb1), .addr1(a_addr1), .dout1(a_dout1), .dout1_valid(a_v1),
        .collision(a_col), .ready(a_rdy)
    );

    sram_1rw1r_sync #(.DATA_WIDTH(64), .ADDR_WIDTH(3), .MASK_GRAN(16),
                      .FORWARD(1'b0), .CLEAR_ON_RESET(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .csb0(b_csb0), .web0(b_web0), .wmask0(b_wmask0), .addr0(b_addr0), .din0(b_din0),
        .dout0(b_dout0), .dout0_valid(b_v0),
        .csb1(b_csb1), .addr1(b_addr1), .dout1(b_dout1), .dout1_valid(b_v1),
        .collision(b_col), .ready(b_rdy)
    );

    // Reference model: arrays plus edges-since-release counters.
    logic [31:0] ma [A_DEPTH];
    logic [63:0] mb [B_DEPTH];
    int unsigned a_cnt, b_cnt;
    logic [31:0] ea_dout0, ea_dout1;
    logic [63:0] eb_dout0, eb_dout1;
    logic        ea_v0, ea_v1, ea_col, ea_rdy;
    logic        eb_v0, eb_v1, eb_col, eb_rdy;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [31:0] merge_a(input logic [31:0] old, input logic [31:0] nw,
                                            input logic [3:0] m);
        logic [31:0] bm;
        for (int i = 0; i < 32; i++) bm[i] = m[i/8];
        return (old & ~bm) | (nw & bm);
    endfunction

    function automatic logic [63:0] merge_b(input logic [63:0] old, input logic [63:0] nw,
                                            input logic [3:0] m);
        logic [63:0] bm;
        for (int i = 0; i < 64; i++) bm[i] = m[i/16];
        return (old & ~bm) | (nw & bm);
    endfunction

    task automatic reset_model();
        a_cnt = 0; b_cnt = 0;
        for (int i = 0; i < int'(A_DEPTH); i++) ma[i] = '0;
        for (int i = 0; i < int'(B_DEPTH); i++) mb[i] = '0;
        ea_dout0 = '0; ea_dout1 = '0; ea_v0 = 1'b0; ea_v1 = 1'b0; ea_col = 1'b0; ea_rdy = 1'b0;
        eb_dout0 = '0; eb_dout1 = '0; eb_v0 = 1'b0; eb_v1 = 1'b0; eb_col = 1'b0; eb_rdy = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_dout0", 64'(a_dout0), 64'(ea_dout0));
        chk("a_v0",    64'(a_v0),    64'(ea_v0));
        chk("a_dout1", 64'(a_dout1), 64'(ea_dout1));
        chk("a_v1",    64'(a_v1),    64'(ea_v1));
        chk("a_col",   64'(a_col),   64'(ea_col));
        chk("a_rdy",   64'(a_rdy),   64'(ea_rdy));
        chk("b_dout0", b_dout0,      eb_dout0);
        chk("b_v0",    64'(b_v0),    64'(eb_v0));
        chk("b_dout1", b_dout1,      eb_dout1);
        chk("b_v1",    64'(b_v1),    64'(eb_v1));
        chk("b_col",   64'(b_col),   64'(eb_col));
        chk("b_rdy",   64'(b_rdy),   64'(eb_rdy));
    endtask

    // One rising edge: advance the model from the inputs seen at that edge, then compare.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            reset_model();
        end else begin
            ea_v0 = 1'b0; ea_v1 = 1'b0; ea_col = 1'b0;
            if (a_cnt >= A_DEPTH) begin
                if (!a_csb0 && a_web0) begin
                    ea_dout0 = ma[a_addr0]; ea_v0 = 1'b1;
                end
                if (!a_csb1) begin
                    ea_dout1 = ma[a_addr1]; ea_v1 = 1'b1;
                    if (!a_csb0 && !a_web0 && a_addr0 == a_addr1) begin
                        ea_col   = 1'b1;
                        ea_dout1 = merge_a(ma[a_addr1], a_din0, a_wmask0);
                    end
                end
                if (!a_csb0 && !a_web0) ma[a_addr0] = merge_a(ma[a_addr0], a_din0, a_wmask0);
            end
            if (a_cnt < A_DEPTH) a_cnt++;
            ea_rdy = (a_cnt >= A_DEPTH);

            eb_v0 = 1'b0; eb_v1 = 1'b0; eb_col = 1'b0;
            if (b_cnt >= B_DEPTH) begin
                if (!b_csb0 && b_web0) begin
                    eb_dout0 = mb[b_addr0]; eb_v0 = 1'b1;
                end
                if (!b_csb1) begin
                    eb_dout1 = mb[b_addr1]; eb_v1 = 1'b1;
                    if (!b_csb0 && !b_web0 && b_addr0 == b_addr1) eb_col = 1'b1;
                end
                if (!b_csb0 && !b_web0) mb[b_addr0] = merge_b(mb[b_addr0], b_din0, b_wmask0);
            end
            if (b_cnt < B_DEPTH) b_cnt++;
            eb_rdy = (b_cnt >= B_DEPTH);
        end
        #1;
        check_all();
    endtask

    task automatic idle_all();
        a_csb0 = 1'b1; a_web0 = 1'b1; a_csb1 = 1'b1;
        b_csb0 = 1'b1; b_web0 = 1'b1; b_csb1 = 1'b1;
    endtask

    task automatic a_write(input logic [3:0] ad, input logic [31:0] d, input logic [3:0] m);
        a_csb0 = 1'b0; a_web0 = 1'b0; a_addr0 = ad; a_din0 = d; a_wmask0 = m;
    endtask

    task automatic b_write(input logic [2:0] ad, input logic [63:0] d, input logic [3:0] m);
        b_csb0 = 1'b0; b_web0 = 1'b0; b_addr0 = ad; b_din0 = d; b_wmask0 = m;
    endtask

    task automatic rand_req();
        a_csb0   = ($urandom_range(0, 3) == 0);
        a_web0   = 1'($urandom_range(0, 1));
        a_wmask0 = 4'($urandom);
        a_din0   = $urandom;
        a_addr0  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom);
        a_csb1   = ($urandom_range(0, 3) == 0);
        a_addr1  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom);
        b_csb0   = ($urandom_range(0, 3) == 0);
        b_web0   = 1'($urandom_range(0, 1));
        b_wmask0 = 4'($urandom);
        b_din0   = {$urandom, $urandom};
        b_addr0  = 3'($urandom_range(0, 3));
        b_csb1   = ($urandom_range(0, 3) == 0);
        b_addr1  = 3'($urandom_range(0, 3));
    endtask

    initial begin
        reset_model();
        repeat (3) tick();
        rst_n = 1'b1;

        // Abort the clear at count 7 with traffic that must be ignored.
        repeat (7) begin
            rand_req();
            tick();
        end
        idle_all();
        rst_n = 1'b0;
        #1;
        reset_model();
        check_all();
        tick();
        rst_n = 1'b1;

        // Full restart: ready must rise exactly RAM_DEPTH edges after release.
        for (int i = 0; i < int'(A_DEPTH); i++) begin
            rand_req();
            if (i == 12) a_write(4'h0, 32'hFFFF_FFFF, 4'hF);
            tick();
            if (i == int'(A_DEPTH) - 2) chk("a_rdy_early", 64'(a_rdy), 64'd0);
        end
        chk("a_rdy_at_depth", 64'(a_rdy), 64'd1);

        // Every address reads back zero after the clear.
        idle_all();
        for (int i = 0; i < int'(A_DEPTH); i++) begin
            a_csb1 = 1'b0; a_addr1 = 4'(i);
            tick();
            chk("a_clear_zero", 64'(a_dout1), 64'd0);
        end

        // Lane merge on a partial write.
        idle_all();
        a_write(4'h5, 32'hAABB_CCDD, 4'b1111); tick();
        a_write(4'h5, 32'h1122_3344, 4'b0101); tick();
        idle_all(); a_csb0 = 1'b0; a_web0 = 1'b1; a_addr0 = 4'h5; tick();
        chk("a_merge", 64'(a_dout0), 64'hAA22_CC44);

        // Same-address write/read collision, forwarding instance.
        idle_all();
        a_write(4'h3, 32'h1234_5678, 4'b1111); tick();
        a_write(4'h3, 32'hDEAD_BEEF, 4'b0011); a_csb1 = 1'b0; a_addr1 = 4'h3; tick();
        chk("a_coll_flag", 64'(a_col), 64'd1);
        chk("a_coll_fwd", 64'(a_dout1), 64'h1234_BEEF);
        idle_all(); a_csb0 = 1'b0; a_web0 = 1'b1; a_addr0 = 4'h3; a_csb1 = 1'b0; a_addr1 = 4'h3; tick();
        chk("a_after_coll", 64'(a_dout0), 64'h1234_BEEF);
        chk("a_dual_read", 64'(a_dout1), 64'h1234_BEEF);
        chk("a_dual_nocoll", 64'(a_col), 64'd0);

        // Deselected ports hold their last data.
        idle_all();
        repeat (5) tick();
        chk("a_hold0", 64'(a_dout0), 64'h1234_BEEF);

        // Non-forwarding instance returns the old word on collision.
        b_write(3'h3, 64'h1111_2222_3333_4444, 4'hF); tick();
        b_write(3'h3, 64'hDEAD_BEEF_CAFE_F00D, 4'b0011); b_csb1 = 1'b0; b_addr1 = 3'h3; tick();
        chk("b_coll_flag", 64'(b_col), 64'd1);
        chk("b_coll_old", b_dout1, 64'h1111_2222_3333_4444);
        idle_all(); b_csb0 = 1'b0; b_web0 = 1'b1; b_addr0 = 3'h3; tick();
        chk("b_after_coll", b_dout0, 64'h1111_2222_CAFE_F00D);

        // Top lane only on the 16-bit-lane instance.
        idle_all();
        b_write(3'h2, 64'h0123_4567_89AB_CDEF, 4'hF); tick();
        b_write(3'h2, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000); tick();
        idle_all(); b_csb0 = 1'b0; b_web0 = 1'b1; b_addr0 = 3'h2; tick();
        chk("b_top_lane", b_dout0, 64'hFFFF_4567_89AB_CDEF);

        // Random traffic concentrated on a few addresses.
        repeat (400) begin
            rand_req();
            tick();
        end

        idle_all();
        repeat (5) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
